// File: rtl/pwm_pkg.sv
// pwm_pkg: shared FSM states, default widths and gate-decode constants for the dead-time stage
package pwm_pkg;
  localparam int DT_WIDTH_DEF = 8;
  typedef enum logic [2:0] {OFF, HI_ON, DT_TO_LO, LO_ON, DT_TO_HI} pwm_dt_state_t;
  // packed as {gate_hi, gate_lo, dt_active}
  localparam logic [2:0] GATES_OFF = 3'b000;
  localparam logic [2:0] GATES_HI  = 3'b100;
  localparam logic [2:0] GATES_LO  = 3'b010;
  localparam logic [2:0] GATES_DT  = 3'b001;
  function automatic logic is_dt(pwm_dt_state_t s);
    return s == DT_TO_LO || s == DT_TO_HI;
  endfunction
  function automatic logic [2:0] gate_decode(pwm_dt_state_t s);
    return s == HI_ON ? GATES_HI : s == LO_ON ? GATES_LO : is_dt(s) ? GATES_DT : GATES_OFF;
  endfunction
endpackage

// File: rtl/pwm_deadtime_gen_if.sv
// pwm_deadtime_gen_if: control and gate-drive signals of the dead-time stage; trip signals with PWM_DT_TRIP_EN
interface pwm_deadtime_gen_if #(parameter int DT_WIDTH = pwm_pkg::DT_WIDTH_DEF);
  logic enable;
  logic pwm_in;
  logic [DT_WIDTH-1:0] dead_time;
  logic gate_hi;
  logic gate_lo;
  logic dt_active;
`ifdef PWM_DT_TRIP_EN
  logic trip_in;
  logic trip_clr;
  logic tripped;
  modport master (output enable, pwm_in, dead_time, trip_in, trip_clr, input gate_hi, gate_lo, dt_active, tripped);
  modport slave (input enable, pwm_in, dead_time, trip_in, trip_clr, output gate_hi, gate_lo, dt_active, tripped);
`else
  modport master (output enable, pwm_in, dead_time, input gate_hi, gate_lo, dt_active);
  modport slave (input enable, pwm_in, dead_time, output gate_hi, gate_lo, dt_active);
`endif
endinterface

// File: rtl/pwm_dt_counter.sv
// pwm_dt_counter: loadable dead-time down-counter; a zero load counts as one, expired flags the last cycle
module pwm_dt_counter #(parameter int W = 8) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] din,
  output logic [W-1:0] value,
  output logic         expired
);
  always_ff @(posedge clk or posedge reset)
    if (reset) value <= '0;
    else if (load) value <= (din == '0) ? W'(1) : din;
    else if (value != '0) value <= value - W'(1);
  assign expired = value == W'(1);
endmodule

// File: rtl/pwm_deadtime_gen.sv
// pwm_deadtime_gen: complementary gate drive with programmable dead time; PWM_DT_TRIP_EN adds a sticky trip
module pwm_deadtime_gen
  import pwm_pkg::*;
#(parameter int DT_WIDTH = DT_WIDTH_DEF) (
  input logic clk,
  input logic reset,
  pwm_deadtime_gen_if.slave bus
);
  pwm_dt_state_t state, state_n;
  logic pwm_q, expired, halt, load;
  logic [DT_WIDTH-1:0] dt_value_unused;
  pwm_dt_counter #(.W(DT_WIDTH)) u_cnt (
    .clk(clk), .reset(reset), .load(load), .din(bus.dead_time),
    .value(dt_value_unused), .expired(expired)
  );
`ifdef PWM_DT_TRIP_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) bus.tripped <= 1'b0;
    else if (bus.trip_in) bus.tripped <= 1'b1;
    else if (bus.trip_clr) bus.tripped <= 1'b0;
  assign halt = bus.trip_in || bus.tripped || !bus.enable;
`else
  assign halt = !bus.enable;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= OFF;
      pwm_q <= 1'b0;
      {bus.gate_hi, bus.gate_lo, bus.dt_active} <= GATES_OFF;
    end else begin
      state <= state_n;
      pwm_q <= bus.pwm_in;
      {bus.gate_hi, bus.gate_lo, bus.dt_active} <= gate_decode(state_n);
    end
  always_comb begin
    state_n = OFF;
    case (state)
      OFF:      state_n = bus.enable ? (pwm_q ? DT_TO_HI : DT_TO_LO) : OFF;
      HI_ON:    state_n = pwm_q ? HI_ON : DT_TO_LO;
      LO_ON:    state_n = pwm_q ? DT_TO_HI : LO_ON;
      DT_TO_LO,
      DT_TO_HI: state_n = expired ? (pwm_q ? HI_ON : LO_ON) : state;
      default:  state_n = OFF;
    endcase
    if (halt) state_n = OFF;
  end
  // the interval length is latched only on entry, so reversals inside it cannot restart it
  assign load = is_dt(state_n) && !is_dt(state);
endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// tb_pwm_deadtime_gen: directed dead-time checks plus a random phase guarding gate exclusivity
module tb_pwm_deadtime_gen;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  pwm_deadtime_gen_if #(.DT_WIDTH(8)) bus ();
  pwm_deadtime_gen #(.DT_WIDTH(8)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic count_gap(output int n);
    n = 0;
    while (bus.dt_active && n < 300) begin
      n++;
      tick();
    end
  endtask

  function automatic logic [31:0] gates();
    return 32'({bus.gate_hi, bus.gate_lo, bus.dt_active});
  endfunction

  task automatic transition(input logic lvl, input int d);
    int n;
    bus.pwm_in = lvl;
    tick();
    check("hold", 32'(lvl ? bus.gate_lo : bus.gate_hi), 1);
    tick();
    check("fall", gates(), 32'b001);
    count_gap(n);
    check("gap", 32'(n), 32'(d));
    check("rise", gates(), lvl ? 32'b100 : 32'b010);
  endtask

  always @(negedge clk) check("excl", 32'(bus.gate_hi & bus.gate_lo), 0);

  initial begin
    int n;
    logic lo_seen;
    bus.enable = 1'b0;
    bus.pwm_in = 1'b0;
    bus.dead_time = 8'd4;
`ifdef PWM_DT_TRIP_EN
    bus.trip_in = 1'b0;
    bus.trip_clr = 1'b0;
`endif
    step(2);
    check("rst_gates", gates(), 0);
    reset = 1'b0;
    tick();
    check("idle", gates(), 0);
    bus.enable = 1'b1;
    tick();
    check("first_dt", gates(), 32'b001);
    step(3);
    check("first_dt_end", gates(), 32'b001);
    tick();
    check("first_lo", gates(), 32'b010);
    transition(1'b1, 4);
    bus.dead_time = 8'd0;
    transition(1'b0, 1);
    transition(1'b1, 1);
    bus.dead_time = 8'd8;
    bus.pwm_in = 1'b0;
    step(2);
    n = 0;
    lo_seen = 1'b0;
    while (bus.dt_active && n < 300) begin
      n++;
      if (n == 2) bus.pwm_in = 1'b1;
      lo_seen |= bus.gate_lo;
      tick();
    end
    check("glitch_gap", 32'(n), 8);
    check("glitch_no_lo", 32'(lo_seen | bus.gate_lo), 0);
    check("glitch_hi", gates(), 32'b100);
    bus.dead_time = 8'd4;
    bus.pwm_in = 1'b0;
    step(2);
    bus.dead_time = 8'd10;
    count_gap(n);
    check("upd_gap", 32'(n), 4);
    check("upd_lo", gates(), 32'b010);
    transition(1'b1, 10);
    bus.enable = 1'b0;
    tick();
    check("en_off", gates(), 0);
    bus.enable = 1'b1;
    tick();
    check("en_dt", gates(), 32'b001);
    count_gap(n);
    check("en_gap", 32'(n), 10);
    check("en_hi", gates(), 32'b100);
    bus.dead_time = 8'd6;
    bus.pwm_in = 1'b0;
    step(2);
    check("pre_rst_dt", gates(), 32'b001);
    step(2);
    reset = 1'b1;
    #1;
    check("async_rst", gates(), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
    check("rst_dt", gates(), 32'b001);
    count_gap(n);
    check("rst_gap", 32'(n), 6);
    check("rst_lo", gates(), 32'b010);
`ifdef PWM_DT_TRIP_EN
    bus.trip_in = 1'b1;
    tick();
    check("trip_gates", gates(), 0);
    check("tripped_set", 32'(bus.tripped), 1);
    bus.trip_in = 1'b0;
    bus.pwm_in = 1'b1;
    step(3);
    check("trip_hold", gates(), 0);
    check("tripped_hold", 32'(bus.tripped), 1);
    bus.trip_clr = 1'b1;
    tick();
    check("tripped_clr", 32'(bus.tripped), 0);
    check("clr_gates", gates(), 0);
    bus.trip_clr = 1'b0;
    tick();
    check("trip_dt", gates(), 32'b001);
    count_gap(n);
    check("trip_gap", 32'(n), 6);
    check("trip_hi", gates(), 32'b100);
`endif
    for (int i = 0; i < 400; i++) begin
      bus.pwm_in = 1'($urandom_range(0, 1));
      bus.dead_time = 8'($urandom_range(0, 5));
      if ($urandom_range(0, 15) == 0) bus.enable = ~bus.enable;
`ifdef PWM_DT_TRIP_EN
      bus.trip_in = $urandom_range(0, 31) == 0;
      bus.trip_clr = $urandom_range(0, 3) == 0;
`endif
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pwm_deadtime_gen.md
# pwm_deadtime_gen

Dead-time insertion stage placed directly downstream of the PWM comparator in bipolar mode. Takes the single positive bipolar PWM level (comparator output P) and produces complementary high-side/low-side gate drives. Both gates stay low for a programmable number of clock cycles around every switching edge, so the two switches of a half-bridge are never commanded on together.

## Interface
Parameters:
- DT_WIDTH, 8, width of the dead-time count; maximum dead time is 2^DT_WIDTH−1 cycles.

Ports:
- clk  input  1  system clock; single clock domain.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  1 = drive gates; 0 = both gates forced low.
- pwm_in  input  1  requested bridge level (1 = high side, 0 = low side), same clock domain.
- dead_time  input  DT_WIDTH  dead-time length in cycles; sampled on entry to a dead-time state.
- gate_hi  output  1  high-side gate drive.
- gate_lo  output  1  low-side gate drive.
- dt_active  output  1  high while a dead-time interval is running.
- trip_in, trip_clr (inputs, 1) and tripped (output, 1) exist only with PWM_DT_TRIP_EN.

## Operation
- pwm_in is registered once into pwm_q. All decisions use pwm_q.
- FSM states: OFF, HI_ON, DT_TO_LO, LO_ON, DT_TO_HI.
- Outputs are registered and decoded from the next state:
  - gate_hi=1 only in HI_ON.
  - gate_lo=1 only in LO_ON.
  - dt_active=1 in DT_TO_LO and DT_TO_HI.
- Transitions:
  - OFF: when enable=1, go to DT_TO_HI if pwm_q=1, else DT_TO_LO. The first turn-on always waits a full dead time.
  - HI_ON: when pwm_q=0, go to DT_TO_LO.
  - LO_ON: when pwm_q=1, go to DT_TO_HI.
  - DT_x: the down-counter loads max(dead_time,1) on entry and decrements each cycle. At expiry, go to HI_ON if pwm_q=1, else LO_ON.
  - A pwm_q reversal during dead time never shortens or restarts the interval. The state reached at expiry follows the current pwm_q.
  - Any state: enable=0 goes to OFF on the next edge, with priority over every other transition.
- dead_time=0 behaves as 1; there is always at least one both-low cycle.
- A dead_time change while a dead-time interval runs is ignored until the next dead-time entry.
- Invariant: gate_hi & gate_lo is never 1, in any cycle.

## Timing
- Reset values: state=OFF, pwm_q=0, counter=0, gate_hi=0, gate_lo=0, dt_active=0, tripped=0.
- pwm_in change stable before edge k:
  - pwm_q updates at edge k.
  - The active gate falls at edge k+1.
  - The opposite gate rises at edge k+1+D, where D = max(dead_time,1).
  - Both gates are low for exactly D cycles.
- enable falling before edge k: both gates low after edge k (1-cycle latency).
- Reset asserted mid-operation: gates go low immediately (asynchronously). After release, a full dead time precedes the first turn-on.
- Simultaneous events: enable=0 wins over counter expiry and over pwm_q edges. Trip (when compiled in) wins over everything except reset.

## Configuration
- PWM_DT_TRIP_EN defined:
  - trip_in=1 sets the sticky tripped flag and forces OFF on the next edge.
  - Gates stay low while tripped=1, regardless of enable.
  - tripped clears on an edge where trip_clr=1 and trip_in=0. Re-entry then proceeds as from OFF, with a full dead time.
- Not defined: the trip ports and the flag are absent; the FSM is as above.

## Structure
- Shared package pwm_pkg:
  - FSM state enum (pwm_dt_state_t).
  - DT_WIDTH default constant.
  - Gate-decode constants.
- Sub-module pwm_dt_counter: loadable down-counter with load, value and expiry pulse, DT_WIDTH wide. Instantiated once.
- FSM, input register and output decode live in pwm_deadtime_gen.

## Test plan
- Basic edge: reset, enable=1, dead_time=4, pwm_in 0→1 before edge 10 → gate_lo falls at edge 11, dt_active high edges 11–15, gate_hi rises at edge 15.
- Zero dead time: dead_time=0, toggle pwm_in → exactly 1 both-low cycle at each transition.
- Glitch inside dead time: dead_time=8, pwm_in 1→0, then back to 1 three cycles later → full 8-cycle gap, then HI_ON; gate_lo never asserts.
- Enable/reset abort: enable low mid-HI_ON → both low next edge; reset asserted mid-DT → outputs 0 asynchronously; after re-enable a full dead time precedes the first gate.
- Dead-time update mid-interval: dead_time 4→10 during DT_TO_LO → current gap stays 4; next transition gap is 10.
- Trip (PWM_DT_TRIP_EN): trip_in pulse during LO_ON → gates low next edge, tripped=1; trip_clr with trip_in=0 → full dead time, then the gate matching pwm_in. Random-stimulus assertion: gate_hi & gate_lo never 1.
